// File: rtl/norestore_divider_pkg.sv
// rtl/norestore_divider_pkg.sv - shared types and sizing helpers for the non-restoring divider
package norestore_divider_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX
   } state_t;

   // Counter must hold the iteration index 0 .. 2*WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(2 * w + 1);
   endfunction

endpackage

// File: rtl/norestore_divider_step.sv
// rtl/norestore_divider_step.sv - one shift / add-or-subtract iteration of non-restoring division
module norestore_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   p_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   p_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;

   // Intermediate shifted value may wrap; the add/sub result always lands back in [-D, D).
   always_comb begin
      shifted = {p_in[WIDTH-1:0], bit_in};
      if (!p_in[WIDTH]) begin
         p_out = shifted - {1'b0, d};
      end else begin
         p_out = shifted + {1'b0, d};
      end
      q_bit = ~p_out[WIDTH];
   end

endmodule

// File: rtl/norestore_divider.sv
// rtl/norestore_divider.sv - sequential unsigned non-restoring divider, one quotient bit per clock
module norestore_divider
   import norestore_divider_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               din_valid,
   output logic [2*WIDTH-1:0] dout,
   output logic [WIDTH-1:0]   remainder,
   output logic               dout_valid
);

   localparam int NB = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NB-1:0]    dvd_q, dvd_d;
   logic [NB-1:0]    quo_q, quo_d;
   logic [NB-1:0]    dout_q, dout_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH:0]   p_q, p_d;
   logic             dz_q, dz_d;
   logic             valid_q, valid_d;

   logic [WIDTH:0]   p_step;
   logic             q_bit;
   logic [WIDTH-1:0] rem_fix;

   norestore_step #(.WIDTH(WIDTH)) u_step (
      .p_in   (p_q),
      .bit_in (dvd_q[NB-1]),
      .d      (dsr_q),
      .p_out  (p_step),
      .q_bit  (q_bit)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      quo_d   = quo_q;
      dout_d  = dout_q;
      dsr_d   = dsr_q;
      rem_d   = rem_q;
      p_d     = p_q;
      dz_d    = dz_q;
      valid_d = 1'b0;
      // Only the low WIDTH bits of the corrected remainder are kept, so add modulo 2^WIDTH.
      rem_fix = p_q[WIDTH-1:0] + (p_q[WIDTH] ? dsr_q : '0);

      if (din_valid) begin
         state_d = ST_RUN;
         cnt_d   = '0;
         dvd_d   = dividend;
         dsr_d   = divisor;
         dz_d    = (divisor == '0);
         quo_d   = '0;
         p_d     = '0;
      end else begin
         case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
               p_d   = p_step;
               quo_d = {quo_q[NB-2:0], q_bit};
               dvd_d = {dvd_q[NB-2:0], 1'b0};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(NB - 1)) begin
                  state_d = ST_FIX;
               end
            end
            ST_FIX: begin
               dout_d  = dz_q ? '1 : quo_q;
               rem_d   = rem_fix;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         quo_q   <= '0;
         dout_q  <= '0;
         dsr_q   <= '0;
         rem_q   <= '0;
         p_q     <= '0;
         dz_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         quo_q   <= quo_d;
         dout_q  <= dout_d;
         dsr_q   <= dsr_d;
         rem_q   <= rem_d;
         p_q     <= p_d;
         dz_q    <= dz_d;
         valid_q <= valid_d;
      end
   end

   assign dout       = dout_q;
   assign remainder  = rem_q;
   assign dout_valid = valid_q;

endmodule

// File: tb/tb_norestore_divider.sv
// tb/tb_norestore_divider.sv - self-checking bench for norestore_divider
module tb_norestore_divider;

   localparam int W = 4;
   localparam int LAT = 2 * W + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [2*W-1:0] dividend = '0;
   logic [W-1:0]   divisor = '0;
   logic           din_valid = 1'b0;
   logic [2*W-1:0] dout;
   logic [W-1:0]   remainder;
   logic           dout_valid;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   logic cmp_en = 1'b0;

   logic           pend = 1'b0;
   int             due = 0;
   logic [2*W-1:0] pa = '0;
   logic [W-1:0]   pd = '0;
   logic [2*W-1:0] m_q = '0;
   logic [W-1:0]   m_r = '0;
   logic           m_v = 1'b0;

   norestore_divider #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .dividend   (dividend),
      .divisor    (divisor),
      .din_valid  (din_valid),
      .dout       (dout),
      .remainder  (remainder),
      .dout_valid (dout_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2*W-1:0] ref_q(input logic [2*W-1:0] a, input logic [W-1:0] d);
      if (d == 0) return '1;
      return a / d;
   endfunction

   function automatic logic [W-1:0] ref_r(input logic [2*W-1:0] a, input logic [W-1:0] d);
      logic [2*W-1:0] r;
      if (d == 0) return a[W-1:0];
      r = a % d;
      return r[W-1:0];
   endfunction

   // Transaction-level model: a start is due LAT edges later unless superseded or reset.
   always @(posedge clk) begin
      cyc++;
      m_v = 1'b0;
      if (rst) begin
         pend = 1'b0;
         m_q  = '0;
         m_r  = '0;
      end else if (din_valid) begin
         pend = 1'b1;
         due  = cyc + LAT;
         pa   = dividend;
         pd   = divisor;
      end else if (pend && cyc == due) begin
         m_q  = ref_q(pa, pd);
         m_r  = ref_r(pa, pd);
         m_v  = 1'b1;
         pend = 1'b0;
      end
   end

   always @(posedge rst) begin
      pend = 1'b0;
      m_q  = '0;
      m_r  = '0;
      m_v  = 1'b0;
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_dout", 32'(dout), 32'(m_q));
         chk("model_rem", 32'(remainder), 32'(m_r));
         chk("model_valid", 32'(dout_valid), 32'(m_v));
      end
   end

   task automatic start(input logic [2*W-1:0] a, input logic [W-1:0] d);
      @(negedge clk);
      dividend  = a;
      divisor   = d;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic [2*W-1:0] eq, input logic [W-1:0] er);
      int n;
      n = 0;
      while (!dout_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_latency"}, 32'(n), 32'(LAT));
      chk({name, "_dout"}, 32'(dout), 32'(eq));
      chk({name, "_rem"}, 32'(remainder), 32'(er));
   endtask

   initial begin
      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_rem", 32'(remainder), 32'd0);
      chk("reset_valid", 32'(dout_valid), 32'd0);
      rst = 1'b0;

      start(8'd200, 4'd7);
      wait_done("d200_7", 8'd28, 4'd4);
      repeat (10) @(negedge clk);
      chk("hold_dout", 32'(dout), 32'd28);
      chk("hold_rem", 32'(remainder), 32'd4);

      start(8'd255, 4'd1);
      wait_done("d255_1", 8'd255, 4'd0);
      start(8'd255, 4'd15);
      wait_done("d255_15", 8'd17, 4'd0);
      start(8'd0, 4'd5);
      wait_done("d0_5", 8'd0, 4'd0);
      start(8'hA6, 4'd0);
      wait_done("div_zero", 8'hFF, 4'h6);

      start(8'd200, 4'd7);
      repeat (3) @(negedge clk);
      start(8'd100, 4'd9);
      wait_done("restart", 8'd11, 4'd1);

      repeat (3) @(negedge clk);
      start(8'd200, 4'd7);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_dout", 32'(dout), 32'd0);
      chk("async_rst_rem", 32'(remainder), 32'd0);
      chk("async_rst_valid", 32'(dout_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      start(8'd13, 4'd3);
      wait_done("d13_3", 8'd4, 4'd1);

      for (int i = 0; i < 1000; i++) begin
         start(8'($urandom_range(0, 255)), 4'($urandom_range(1, 15)));
         repeat (19) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
